// File: rtl/display_mux_ctrl_if.sv
// rtl/display_mux_ctrl_if.sv - switch input and display/LED output bundle for display_mux_ctrl
interface display_mux_ctrl_if;
    logic [7:0] s;
    logic [3:0] digit;
    logic [1:0] an;
    logic [4:0] led;
    logic       frame;

    modport master (
        output s,
        input  digit,
        input  an,
        input  led,
        input  frame
    );

    modport slave (
        input  s,
        output digit,
        output an,
        output led,
        output frame
    );
endinterface

// File: rtl/display_mux_ctrl.sv
// rtl/display_mux_ctrl.sv - time-multiplexed dual seven-segment driver with per-frame sampled LED sum
module display_mux_ctrl #(
    parameter int SHOW_CYCLES  = 12000,
    parameter int BLANK_CYCLES = 120
) (
    input  logic              clk,
    input  logic              reset,
    display_mux_ctrl_if.slave bus
);
    localparam int MAX_N = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        BLANK1 = 2'd0,
        SHOW0  = 2'd1,
        BLANK0 = 2'd2,
        SHOW1  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    s_reg_q;
    logic [4:0]    led_q;
    logic [1:0]    an_q;
    logic [3:0]    digit_q;
    logic          frame_q;

    logic          dwell_last_d;
    logic          sample_d;

    always_comb begin
        dwell_last_d = 1'b0;
        sample_d     = 1'b0;
        if (state_q == SHOW0 || state_q == SHOW1) begin
            dwell_last_d = (cnt_q == SHOW_LAST);
        end else begin
            dwell_last_d = (cnt_q == BLANK_LAST);
        end
        sample_d = (state_q == BLANK1) && (cnt_q == '0);
    end

    // an/digit are registered alongside the state so the pins never see a decode glitch;
    // digit only moves on entry to a blanking state (or at the sample edge, still dark).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK1;
            cnt_q   <= '0;
            s_reg_q <= '0;
            led_q   <= '0;
            an_q    <= 2'b11;
            digit_q <= '0;
            frame_q <= 1'b1;
        end else begin
            frame_q <= 1'b0;
            if (sample_d) begin
                s_reg_q <= bus.s;
                led_q   <= {1'b0, bus.s[3:0]} + {1'b0, bus.s[7:4]};
                digit_q <= bus.s[3:0];
            end
            if (dwell_last_d) begin
                cnt_q <= '0;
                case (state_q)
                    BLANK1: begin
                        state_q <= SHOW0;
                        an_q    <= 2'b10;
                    end
                    SHOW0: begin
                        state_q <= BLANK0;
                        an_q    <= 2'b11;
                        digit_q <= s_reg_q[7:4];
                    end
                    BLANK0: begin
                        state_q <= SHOW1;
                        an_q    <= 2'b01;
                    end
                    default: begin
                        state_q <= BLANK1;
                        an_q    <= 2'b11;
                        digit_q <= s_reg_q[3:0];
                        frame_q <= 1'b1;
                    end
                endcase
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.an    = an_q;
    assign bus.digit = digit_q;
    assign bus.led   = led_q;
    assign bus.frame = frame_q & ~reset;
endmodule
